// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver.
//
// Synchronises the serial line, validates the start bit at mid-bit, then
// samples eight data bits (LSB first) and the stop bit at the middle of each
// bit period. A good frame updates o_rx_byte with a one-cycle o_rx_done
// pulse. A low stop bit gives a one-cycle o_rx_frame_err pulse and leaves
// o_rx_byte unchanged.
//
// Optional build macro: UART_RX_MAJORITY_VOTE_EN
//   When defined, each sample point takes the majority of the last three
//   synchronised line values, so single-cycle glitches are rejected.
//
// Parameters:
//   CLOCK_FREQUENCY  i_clk frequency in Hz
//   BAUD_RATE        line rate in bit/s (CLOCK_FREQUENCY/BAUD_RATE must be >= 8)
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_rx_serial     asynchronous serial input, idle high
//   o_rx_byte       last correctly received byte
//   o_rx_done       one-cycle pulse when o_rx_byte is updated
//   o_rx_frame_err  one-cycle pulse when the stop bit samples low
//   o_rx_busy       high while a frame is being received
//
// state     | meaning
// WAIT_IDLE | waiting for one full bit time of continuous high line
// IDLE      | line idle, waiting for a falling edge
// START     | timing to the middle of the start bit to validate it
// DATA      | sampling the eight data bits at mid-bit
// STOP      | sampling the stop bit at mid-bit

module uart_rx #(
    parameter int CLOCK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE       = 115200
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rx_serial,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_done,
    output logic       o_rx_frame_err,
    output logic       o_rx_busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [2:0]       idx, idx_nx;
    logic [7:0]       shift, shift_nx;
    logic [7:0]       rx_byte_nx;
    logic             done_nx, err_nx;
    logic             rx_meta, rx_s;
    logic             sample;

`ifdef UART_RX_MAJORITY_VOTE_EN
    // Two older copies of rx_s; together with rx_s they form the vote window.
    logic [1:0] hist;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample = (rx_s & hist[0]) | (rx_s & hist[1]) | (hist[0] & hist[1]);
`else
    assign sample = rx_s;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_meta        <= 1'b1;
            rx_s           <= 1'b1;
            state          <= WAIT_IDLE;
            cnt            <= '0;
            idx            <= '0;
            shift          <= '0;
            o_rx_byte      <= '0;
            o_rx_done      <= 1'b0;
            o_rx_frame_err <= 1'b0;
        end else begin
            rx_meta        <= i_rx_serial;
            rx_s           <= rx_meta;
            state          <= state_nx;
            cnt            <= cnt_nx;
            idx            <= idx_nx;
            shift          <= shift_nx;
            o_rx_byte      <= rx_byte_nx;
            o_rx_done      <= done_nx;
            o_rx_frame_err <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        idx_nx     = idx;
        shift_nx   = shift;
        rx_byte_nx = o_rx_byte;
        done_nx    = 1'b0;
        err_nx     = 1'b0;

        case (state)
            WAIT_IDLE: begin
                // Only a full bit time of unbroken high line re-arms the
                // receiver, so it never locks onto the middle of a frame.
                if (!rx_s) begin
                    cnt_nx = '0;
                end else if (cnt == CNT_FULL) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_nx   = '0;
                    idx_nx   = '0;
                    state_nx = sample ? IDLE : DATA;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_FULL) begin
                    cnt_nx        = '0;
                    shift_nx[idx] = sample;
                    if (idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        idx_nx = idx + 3'd1;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                // Leaving mid-stop-bit gives half a bit of slack to catch a
                // start bit that follows immediately.
                if (cnt == CNT_FULL) begin
                    cnt_nx = '0;
                    if (sample) begin
                        rx_byte_nx = shift;
                        done_nx    = 1'b1;
                        state_nx   = IDLE;
                    end else begin
                        err_nx   = 1'b1;
                        state_nx = WAIT_IDLE;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = WAIT_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    assign o_rx_busy = (state == START) || (state == DATA) || (state == STOP);

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 16 clocks per bit. Frames are described in a
// vector table; each expected pulse is queued when its frame starts and is
// checked by a monitor when the DUT pulses. Glitch and mid-frame reset cases
// are written out by hand.

module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LATENCY = 2 + 8 + 9 * 16 + 1;

    logic       clk = 1'b0;
    logic       i_rst;
    logic       i_rx_serial;
    logic [7:0] o_rx_byte;
    logic       o_rx_done;
    logic       o_rx_frame_err;
    logic       o_rx_busy;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        int         fall;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        int         glitch_bit;
        int         idle_after;
        logic       exp_err;
        logic [7:0] exp_byte;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(
        .CLOCK_FREQUENCY(1_600_000),
        .BAUD_RATE      (100_000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_rx_serial   (i_rx_serial),
        .o_rx_byte     (o_rx_byte),
        .o_rx_done     (o_rx_done),
        .o_rx_frame_err(o_rx_frame_err),
        .o_rx_busy     (o_rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pulse width, exclusivity, and scoreboard comparison.
    logic prev_pulse = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (prev_pulse) begin
            check("pulse_width", !(o_rx_done || o_rx_frame_err),
                  {30'd0, o_rx_done, o_rx_frame_err}, 32'd0);
        end
        if (o_rx_done || o_rx_frame_err) begin
            check("exclusive", !(o_rx_done && o_rx_frame_err),
                  {30'd0, o_rx_done, o_rx_frame_err}, 32'd1);
            check("expected_pulse", sb.size() != 0, sb.size(), 32'd1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("pulse_kind", o_rx_frame_err == mon_e.is_err,
                      {31'd0, o_rx_frame_err}, {31'd0, mon_e.is_err});
                check("rx_byte", o_rx_byte == mon_e.data, {24'd0, o_rx_byte}, {24'd0, mon_e.data});
                check("latency", (cyc - mon_e.fall) == LATENCY, cyc - mon_e.fall, LATENCY);
            end
        end
        prev_pulse <= o_rx_done || o_rx_frame_err;
    end

    // Drives one 10-bit frame, one pin value per clock, changing #1 after
    // the rising edge. Optionally inverts one data bit for a single cycle at
    // its sample point, and optionally pulses reset at a given pin cycle.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                              input int glitch_bit, input int rst_at,
                              input logic push, input logic exp_err,
                              input logic [7:0] exp_byte);
        logic [9:0] bits;
        logic       v;
        exp_t       e;
        bits = {stop_bit, d, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            @(posedge clk);
            #1;
            if (c == 0 && push) begin
                e.is_err = exp_err;
                e.data   = exp_byte;
                e.fall   = cyc;
                sb.push_back(e);
            end
            v = bits[c / CPB];
            if (glitch_bit >= 0 && c == CPB * (glitch_bit + 1) + CPB / 2) v = ~v;
            i_rx_serial = v;
            i_rst       = (c == rst_at);
        end
    endtask

    task automatic idle_line(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            i_rx_serial = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        logic [7:0] glitch_exp;

`ifdef UART_RX_MAJORITY_VOTE_EN
        glitch_exp = 8'h5A;
`else
        glitch_exp = 8'h58;
`endif
        //          data   stop  glitch idle  err   o_rx_byte after frame
        vecs[0] = '{8'hA5, 1'b1, -1,    20,   1'b0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, -1,    0,    1'b0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, -1,    0,    1'b0, 8'hFF};
        vecs[3] = '{8'h55, 1'b1, -1,    20,   1'b0, 8'h55};
        vecs[4] = '{8'h3C, 1'b0, -1,    16,   1'b1, 8'h55};
        vecs[5] = '{8'h81, 1'b1, -1,    20,   1'b0, 8'h81};
        vecs[6] = '{8'h5A, 1'b1, 1,     20,   1'b0, glitch_exp};

        i_rst       = 1'b1;
        i_rx_serial = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        i_rst = 1'b0;
        @(negedge clk);
        check("reset_byte", o_rx_byte == 8'h00, {24'd0, o_rx_byte}, 32'h00);
        check("reset_done", o_rx_done == 1'b0, {31'd0, o_rx_done}, 32'd0);
        check("reset_err", o_rx_frame_err == 1'b0, {31'd0, o_rx_frame_err}, 32'd0);
        check("reset_busy", o_rx_busy == 1'b0, {31'd0, o_rx_busy}, 32'd0);
        idle_line(20);

        for (int i = 0; i < 7; i++) begin
            send_frame(vecs[i].data, vecs[i].stop_bit, vecs[i].glitch_bit, -1,
                       1'b1, vecs[i].exp_err, vecs[i].exp_byte);
            idle_line(vecs[i].idle_after);
            check("sb_drain", sb.size() == 0, sb.size(), 32'd0);
            sb.delete();
            check("byte_after_frame", o_rx_byte == vecs[i].exp_byte,
                  {24'd0, o_rx_byte}, {24'd0, vecs[i].exp_byte});
        end

        // Short low glitch on an idle line: START aborts, no pulse.
        @(posedge clk);
        #1;
        i_rx_serial = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_rx_busy) busy_cnt++;
            if (c == 0) i_rx_serial = 1'b1;
        end
        check("glitch_busy_cycles", busy_cnt == 8, busy_cnt, 32'd8);
        check("glitch_busy_low", o_rx_busy == 1'b0, {31'd0, o_rx_busy}, 32'd0);
        check("glitch_no_pulse", sb.size() == 0, sb.size(), 32'd0);
        idle_line(20);

        // Reset during bit 6 of 0x12: frame is dropped, byte clears.
        send_frame(8'h12, 1'b1, -1, CPB * 7 + 4, 1'b0, 1'b0, 8'h00);
        idle_line(20);
        check("rst_byte_cleared", o_rx_byte == 8'h00, {24'd0, o_rx_byte}, 32'h00);
        check("rst_busy_low", o_rx_busy == 1'b0, {31'd0, o_rx_busy}, 32'd0);
        send_frame(8'h34, 1'b1, -1, -1, 1'b1, 1'b0, 8'h34);
        idle_line(20);
        check("post_rst_drain", sb.size() == 0, sb.size(), 32'd0);
        check("post_rst_byte", o_rx_byte == 8'h34, {24'd0, o_rx_byte}, 32'h34);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
